// File: rtl/tangram_param_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tangram_param_unit_if : input/result bundle of tangram_param_unit     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tangram_param_unit_if #(
  parameter int DATAW = 16,
  parameter int PIXLW = 12
);
  logic signed [DATAW-1:0] angle_in;
  logic signed [DATAW-1:0] angle_prev;
  logic signed [DATAW-1:0] angle_next;
  logic        [DATAW-1:0] cur_x;
  logic        [DATAW-1:0] cur_y;
  logic        [DATAW-1:0] scan_x;
  logic        [DATAW-1:0] scan_y;
  logic        [PIXLW-1:0] pick_color;
  logic        [PIXLW-1:0] render_color;
  logic                    in_picker;
  logic        [DATAW-1:0] dec_in;
  logic        [DATAW-1:0] dec_quot;
  logic              [3:0] dec_rem;
  logic              [3:0] dig0;
  logic              [3:0] dig1;
  logic              [3:0] dig2;

  modport master (
    output angle_in, cur_x, cur_y, scan_x, scan_y, dec_in,
    input  angle_prev, angle_next, pick_color, render_color, in_picker,
           dec_quot, dec_rem, dig0, dig1, dig2
  );

  modport slave (
    input  angle_in, cur_x, cur_y, scan_x, scan_y, dec_in,
    output angle_prev, angle_next, pick_color, render_color, in_picker,
           dec_quot, dec_rem, dig0, dig1, dig2
  );
endinterface
`default_nettype wire

// File: rtl/tangram_param_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tangram_param_unit : registered angle stepper, palette and /10 unit  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tangram_param_unit #(
  parameter int DATAW      = 16,
  parameter int PIXLW      = 12,
  parameter int COLRW      = 4,
  parameter int DW_BOUND   = -180,
  parameter int UP_BOUND   = 179,
  parameter int COLOR_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  tangram_param_unit_if.slave  bus
);

  localparam int K         = $clog2(COLOR_SIZE);
  localparam int DIV_SHIFT = DATAW + 3;
  localparam int PW        = 2 * DATAW + 4;

  localparam logic signed [DATAW-1:0] C_DW_BOUND = DATAW'(DW_BOUND);
  localparam logic signed [DATAW-1:0] C_UP_BOUND = DATAW'(UP_BOUND);
  localparam logic signed [DATAW-1:0] C_ONE_S    = DATAW'(1);
  localparam logic        [DATAW-1:0] C_ONE_U    = DATAW'(1);
  localparam logic        [DATAW-1:0] C_TEN      = DATAW'(10);
  localparam logic        [DATAW-1:0] C_SIZE     = DATAW'(COLOR_SIZE);
  localparam logic signed   [DATAW:0] C_NEG3     = -(DATAW+1)'(3);
  localparam logic signed   [DATAW:0] C_POS3     = (DATAW+1)'(3);
  localparam logic signed   [DATAW:0] C_ZERO     = '0;
  // floor(2^S/10): the estimate is at most one below the true quotient
  localparam logic          [DATAW:0] C_RECIP    = (DATAW+1)'((64'd1 << DIV_SHIFT) / 64'd10);

  function automatic logic [PIXLW-1:0] pal(input logic [COLRW-1:0] r,
                                           input logic [COLRW-1:0] g);
    logic [COLRW:0]   s;
    logic [COLRW-1:0] b;
    s = {1'b0, r} + {1'b0, g};
    b = {COLRW{1'b1}} - s[COLRW:1];
    return {r, g, b};
  endfunction

  function automatic logic [DATAW-1:0] div10(input logic [DATAW-1:0] v);
    logic [DATAW-1:0] q;
    logic       [4:0] r;
    q = DATAW'((PW'(v) * PW'(C_RECIP)) >> DIV_SHIFT);
    r = 5'(v - q * C_TEN);
    if (r >= 5'd10) q = q + C_ONE_U;
    return q;
  endfunction

  logic signed [DATAW-1:0] angle_prev_d, angle_prev_q;
  logic signed [DATAW-1:0] angle_next_d, angle_next_q;
  logic        [PIXLW-1:0] pick_color_d, pick_color_q;
  logic        [PIXLW-1:0] render_color_d, render_color_q;
  logic                    in_picker_d, in_picker_q;
  logic        [DATAW-1:0] dec_quot_d, dec_quot_q;
  logic              [3:0] dec_rem_d, dec_rem_q;
  logic              [3:0] dig1_d, dig1_q;
  logic              [3:0] dig2_d, dig2_q;

  logic        [PIXLW-1:0] scan_pal;
  logic signed   [DATAW:0] dx;
  logic signed   [DATAW:0] dy;
  logic                    marker;
  logic        [DATAW-1:0] q_tens;
  logic        [DATAW-1:0] q_hund;

  always_comb begin
    angle_prev_d = bus.angle_in - C_ONE_S;
    angle_next_d = bus.angle_in + C_ONE_S;
    if (bus.angle_in < C_DW_BOUND || bus.angle_in > C_UP_BOUND) begin
      angle_prev_d = C_DW_BOUND;
      angle_next_d = C_DW_BOUND;
    end else begin
      if (bus.angle_in == C_DW_BOUND) angle_prev_d = C_UP_BOUND;
      if (bus.angle_in == C_UP_BOUND) angle_next_d = C_DW_BOUND;
    end
  end

  always_comb begin
    pick_color_d = pal(bus.cur_x[K-1 -: COLRW], bus.cur_y[K-1 -: COLRW]);
    scan_pal     = pal(bus.scan_x[K-1 -: COLRW], bus.scan_y[K-1 -: COLRW]);
    in_picker_d  = (bus.scan_x < C_SIZE) && (bus.scan_y < C_SIZE);
    // Differences carry one extra bit so the full unsigned range stays exact
    dx = $signed({1'b0, bus.scan_x}) - $signed({1'b0, bus.cur_x});
    dy = $signed({1'b0, bus.scan_y}) - $signed({1'b0, bus.cur_y});
    marker = ((dx == C_ZERO) && (dy >= C_NEG3) && (dy <= C_POS3)) ||
             ((dy == C_ZERO) && (dx >= C_NEG3) && (dx <= C_POS3));
    render_color_d = '0;
    if (in_picker_d) render_color_d = marker ? ~scan_pal : scan_pal;
  end

  always_comb begin
    dec_quot_d = div10(bus.dec_in);
    q_tens     = div10(dec_quot_d);
    q_hund     = div10(q_tens);
    dec_rem_d  = 4'(bus.dec_in - dec_quot_d * C_TEN);
    dig1_d     = 4'(dec_quot_d - q_tens * C_TEN);
    dig2_d     = 4'(q_tens - q_hund * C_TEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      angle_prev_q   <= '0;
      angle_next_q   <= '0;
      pick_color_q   <= '0;
      render_color_q <= '0;
      in_picker_q    <= 1'b0;
      dec_quot_q     <= '0;
      dec_rem_q      <= '0;
      dig1_q         <= '0;
      dig2_q         <= '0;
    end else begin
      angle_prev_q   <= angle_prev_d;
      angle_next_q   <= angle_next_d;
      pick_color_q   <= pick_color_d;
      render_color_q <= render_color_d;
      in_picker_q    <= in_picker_d;
      dec_quot_q     <= dec_quot_d;
      dec_rem_q      <= dec_rem_d;
      dig1_q         <= dig1_d;
      dig2_q         <= dig2_d;
    end
  end

  assign bus.angle_prev   = angle_prev_q;
  assign bus.angle_next   = angle_next_q;
  assign bus.pick_color   = pick_color_q;
  assign bus.render_color = render_color_q;
  assign bus.in_picker    = in_picker_q;
  assign bus.dec_quot     = dec_quot_q;
  assign bus.dec_rem      = dec_rem_q;
  assign bus.dig0         = dec_rem_q;
  assign bus.dig1         = dig1_q;
  assign bus.dig2         = dig2_q;

endmodule
`default_nettype wire

// File: tb/tb_tangram_param_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tangram_param_unit : vector table, randomized model and /10 sweep |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tangram_param_unit;

  localparam int DATAW      = 16;
  localparam int PIXLW      = 12;
  localparam int COLRW      = 4;
  localparam int DW_BOUND   = -180;
  localparam int UP_BOUND   = 179;
  localparam int COLOR_SIZE = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tangram_param_unit_if #(.DATAW(DATAW), .PIXLW(PIXLW)) bus ();

  tangram_param_unit #(
    .DATAW(DATAW), .PIXLW(PIXLW), .COLRW(COLRW),
    .DW_BOUND(DW_BOUND), .UP_BOUND(UP_BOUND), .COLOR_SIZE(COLOR_SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic signed [15:0] angle;
    logic        [15:0] cx, cy, sx, sy, dec;
  } in_t;

  typedef struct {
    logic signed [15:0] prev, next;
    logic        [11:0] pick, rend;
    logic               inp;
    logic        [15:0] quot;
    logic         [3:0] rem, d0, d1, d2;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];

  function automatic in_t mk_in(int a, int cx, int cy, int sx, int sy, int d);
    in_t v;
    v.angle = 16'(a); v.cx = 16'(cx); v.cy = 16'(cy);
    v.sx = 16'(sx);   v.sy = 16'(sy); v.dec = 16'(d);
    return v;
  endfunction

  function automatic out_t mk_out(int p, int n, int pk, int rd, int ip,
                                  int q, int r, int d0, int d1, int d2);
    out_t o;
    o.prev = 16'(p); o.next = 16'(n); o.pick = 12'(pk); o.rend = 12'(rd);
    o.inp = ip[0]; o.quot = 16'(q); o.rem = 4'(r);
    o.d0 = 4'(d0); o.d1 = 4'(d1); o.d2 = 4'(d2);
    return o;
  endfunction

  function automatic int pal_m(int x, int y);
    int r, g, b;
    r = (x % COLOR_SIZE) / (COLOR_SIZE / 16);
    g = (y % COLOR_SIZE) / (COLOR_SIZE / 16);
    b = 15 - (r + g) / 2;
    return r * 256 + g * 16 + b;
  endfunction

  function automatic out_t model(in_t v);
    int a, span, dx, dy, sx, sy, p, d;
    bit mk, ip;
    a = v.angle;
    span = UP_BOUND - DW_BOUND + 1;
    if (a < DW_BOUND || a > UP_BOUND) begin
      model.prev = 16'(DW_BOUND);
      model.next = 16'(DW_BOUND);
    end else begin
      model.next = 16'(DW_BOUND + (a - DW_BOUND + 1) % span);
      model.prev = 16'(DW_BOUND + (a - DW_BOUND - 1 + span) % span);
    end
    model.pick = 12'(pal_m(int'(v.cx), int'(v.cy)));
    sx = int'(v.sx); sy = int'(v.sy);
    dx = sx - int'(v.cx);
    dy = sy - int'(v.cy);
    ip = (sx < COLOR_SIZE) && (sy < COLOR_SIZE);
    mk = (dx == 0 && dy >= -3 && dy <= 3) || (dy == 0 && dx >= -3 && dx <= 3);
    p = pal_m(sx, sy);
    model.inp = ip;
    model.rend = !ip ? 12'd0 : (mk ? 12'(12'hFFF - p) : 12'(p));
    d = int'(v.dec);
    model.quot = 16'(d / 10);
    model.rem  = 4'(d % 10);
    model.d0   = 4'(d % 10);
    model.d1   = 4'((d / 10) % 10);
    model.d2   = 4'((d / 100) % 10);
  endfunction

  task automatic drive(in_t v);
    bus.angle_in = v.angle;
    bus.cur_x = v.cx;  bus.cur_y = v.cy;
    bus.scan_x = v.sx; bus.scan_y = v.sy;
    bus.dec_in = v.dec;
  endtask

  task automatic chk(string name, logic signed [31:0] got, logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(string tag, out_t e);
    chk({tag, ".angle_prev"},   bus.angle_prev,   e.prev);
    chk({tag, ".angle_next"},   bus.angle_next,   e.next);
    chk({tag, ".pick_color"},   bus.pick_color,   e.pick);
    chk({tag, ".render_color"}, bus.render_color, e.rend);
    chk({tag, ".in_picker"},    bus.in_picker,    e.inp);
    chk({tag, ".dec_quot"},     bus.dec_quot,     e.quot);
    chk({tag, ".dec_rem"},      bus.dec_rem,      e.rem);
    chk({tag, ".dig0"},         bus.dig0,         e.d0);
    chk({tag, ".dig1"},         bus.dig1,         e.d1);
    chk({tag, ".dig2"},         bus.dig2,         e.d2);
  endtask

  task automatic step(in_t v, string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_out(tag, model(v));
  endtask

  function automatic in_t rand_in();
    in_t v;
    int a, cx, cy, sx, sy;
    case ($urandom_range(0, 3))
      0:       a = DW_BOUND - 1 + int'($urandom_range(0, 2));
      1:       a = UP_BOUND - 1 + int'($urandom_range(0, 2));
      default: a = int'($urandom_range(0, 800)) - 400;
    endcase
    cx = int'($urandom_range(0, COLOR_SIZE - 1));
    cy = int'($urandom_range(0, COLOR_SIZE - 1));
    case ($urandom_range(0, 3))
      0: begin sx = cx; sy = cy + int'($urandom_range(0, 10)) - 5; end
      1: begin sy = cy; sx = cx + int'($urandom_range(0, 10)) - 5; end
      2: begin sx = int'($urandom_range(0, 200)); sy = int'($urandom_range(0, 200)); end
      default: begin sx = int'($urandom_range(0, 65535)); sy = int'($urandom_range(0, 65535)); end
    endcase
    v = mk_in(a, cx, cy, sx, sy, int'($urandom_range(0, 65535)));
    return v;
  endfunction

  initial begin
    vecs[0] = '{i: mk_in( 179,   0,   0, 128,   5,   359), e: mk_out( 178, -180, 'h00F, 'h000, 0,   35, 9, 9, 5, 3)};
    vecs[1] = '{i: mk_in(-180,  10,  10,  10,  12,     0), e: mk_out( 179, -179, 'h11E, 'hEE1, 1,    0, 0, 0, 0, 0)};
    vecs[2] = '{i: mk_in(   0,  10,  10,  10,  14, 65535), e: mk_out(  -1,    1, 'h11E, 'h11E, 1, 6553, 5, 5, 3, 5)};
    vecs[3] = '{i: mk_in( 500, 127, 127,   0,   0,    10), e: mk_out(-180, -180, 'hFF0, 'h00F, 1,    1, 0, 0, 1, 0)};
    vecs[4] = '{i: mk_in(-181,  64,   0,  64,   3,   100), e: mk_out(-180, -180, 'h80B, 'h7F4, 1,   10, 0, 0, 0, 1)};
    vecs[5] = '{i: mk_in( 178,  64,   0,  64,   4,   999), e: mk_out( 177,  179, 'h80B, 'h80B, 1,   99, 9, 9, 9, 9)};
    vecs[6] = '{i: mk_in(-179,  64,   0,  61,   0, 12345), e: mk_out(-180, -178, 'h80B, 'h8F3, 1, 1234, 5, 5, 4, 3)};
    vecs[7] = '{i: mk_in(  -1,   5, 127,   5, 128, 65534), e: mk_out(  -2,    0, 'h0F8, 'h000, 0, 6553, 4, 4, 3, 5)};

    // Reset holds outputs at zero even with live inputs
    rst = 1'b1;
    drive(vecs[2].i);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("first", vecs[2].e);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].i);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e);
    end

    // Outputs must hold between edges, then follow one edge later
    drive(vecs[0].i);
    #2;
    check_out("lat_hold", vecs[7].e);
    @(posedge clk);
    #1;
    check_out("lat_upd", vecs[0].e);

    @(negedge clk);
    drive(vecs[1].i);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_out("mid_rst", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_rst", vecs[1].e);

    for (int n = 0; n < 3000; n++) step(rand_in(), "rand");

    for (int d = 0; d < 65536; d++) begin
      in_t v;
      v = rand_in();
      v.dec = 16'(d);
      step(v, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
